// File: rtl/lmem_pkg.sv
// lmem_pkg: shared state enum, default sizes and width helper
// for the local memory bank.
package lmem_pkg;

    localparam int LMEM_LINE_BITS = 512;
    localparam int LMEM_DEPTH     = 8;
    localparam int LMEM_BEAT_BITS = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_CLEAR  = 2'd2
    } lmem_state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/lmem_beat_shifter.sv
// lmem_beat_shifter: snapshots one line and presents it as
// a valid/ready beat stream, lowest beat first.
module lmem_beat_shifter
    import lmem_pkg::*;
#(
    parameter int LINE_BITS = LMEM_LINE_BITS,
    parameter int BEAT_BITS = LMEM_BEAT_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [LINE_BITS-1:0] line_in,
    input  logic                 ready,
    output logic [BEAT_BITS-1:0] data,
    output logic                 valid,
    output logic                 last,
    output logic                 done
);

    localparam int NBEATS = LINE_BITS / BEAT_BITS;
    localparam int CW = (NBEATS > 1) ? clog2(NBEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(NBEATS - 1);

    logic [LINE_BITS-1:0] snap;
    logic [CW-1:0]        cnt;
    logic                 fire;

    assign fire = valid & ready;
    assign last = valid & (cnt == LAST_BEAT);
    assign done = fire & last;
    assign data = snap[BEAT_BITS-1:0];

    // Snapshot is private, so later array writes cannot reach it.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap  <= '0;
            cnt   <= '0;
            valid <= 1'b0;
        end else if (load) begin
            snap  <= line_in;
            cnt   <= '0;
            valid <= 1'b1;
        end else if (done) begin
            snap  <= '0;
            cnt   <= '0;
            valid <= 1'b0;
        end else if (fire) begin
            snap <= snap >> BEAT_BITS;
            cnt  <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/local_mem_bank.sv
// local_mem_bank: line-wide memory with chunk, host-byte and beat-stream
// ports. Define LMEM_PARITY_EN for per-line parity and parity_err.
module local_mem_bank
    import lmem_pkg::*;
#(
    parameter int LINE_BITS = LMEM_LINE_BITS,
    parameter int DEPTH     = LMEM_DEPTH,
    parameter int BEAT_BITS = LMEM_BEAT_BITS,
    localparam int LW = clog2(DEPTH),
    localparam int BW = clog2(LINE_BITS / 8)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 chunk_wr,
    input  logic [LW-1:0]        chunk_wr_line,
    input  logic [LINE_BITS-1:0] chunk_in,
    input  logic [LW-1:0]        chunk_rd_line,
    output logic [LINE_BITS-1:0] chunk_out,
    input  logic                 host_valid,
    input  logic                 host_we,
    input  logic [LW+BW-1:0]     host_addr,
    input  logic [7:0]           host_wdata,
    output logic                 host_ready,
    output logic [7:0]           host_rdata,
    output logic                 host_rvalid,
    input  logic                 clear,
    input  logic                 strm_start,
    input  logic [LW-1:0]        strm_line,
    input  logic                 strm_ready,
    output logic [BEAT_BITS-1:0] strm_data,
    output logic                 strm_valid,
    output logic                 strm_last,
    output logic                 busy
`ifdef LMEM_PARITY_EN
    ,
    output logic                 parity_err
`endif
);

    localparam logic [LW-1:0] LAST_LINE = LW'(DEPTH - 1);

    lmem_state_e state, state_nxt;

    logic [LINE_BITS-1:0] mem [DEPTH];
    logic [LW-1:0]        clr_cnt;
    logic [LW-1:0]        h_line;
    logic [BW-1:0]        h_byte;
    logic [LINE_BITS-1:0] h_cur;
    logic [LINE_BITS-1:0] h_new;
    logic                 c_wr;
    logic                 h_wr;
    logic                 h_rd;
    logic                 load;
    logic                 done;

    assign h_line = host_addr[LW+BW-1:BW];
    assign h_byte = host_addr[BW-1:0];
    assign h_cur  = mem[h_line];

    always_comb begin
        h_new = h_cur;
        h_new[{h_byte, 3'b000} +: 8] = host_wdata;
    end

    // A chunk write to the same line beats a host write.
    assign host_ready = (state != ST_CLEAR) &&
                        !(host_we && chunk_wr && (chunk_wr_line == h_line));
    assign c_wr = chunk_wr && (state != ST_CLEAR);
    assign h_wr = host_valid && host_ready && host_we;
    assign h_rd = host_valid && host_ready && !host_we;
    assign load = (state == ST_IDLE) && !clear && strm_start;
    assign busy = (state != ST_IDLE);

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (clear)           state_nxt = ST_CLEAR;
                else if (strm_start) state_nxt = ST_STREAM;
            end
            ST_STREAM: begin
                if (done) state_nxt = ST_IDLE;
            end
            ST_CLEAR: begin
                if (clr_cnt == LAST_LINE) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= (state == ST_CLEAR) ? clr_cnt + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (state == ST_CLEAR) begin
            mem[clr_cnt] <= '0;
        end else begin
            if (c_wr) mem[chunk_wr_line] <= chunk_in;
            if (h_wr) mem[h_line] <= h_new;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chunk_out   <= '0;
            host_rdata  <= '0;
            host_rvalid <= 1'b0;
        end else begin
            chunk_out   <= mem[chunk_rd_line];
            host_rvalid <= h_rd;
            if (h_rd) host_rdata <= h_cur[{h_byte, 3'b000} +: 8];
        end
    end

`ifdef LMEM_PARITY_EN
    logic [DEPTH-1:0] par;
    logic             chunk_par;

    always_ff @(posedge clk) begin
        if (rst) begin
            par        <= '0;
            chunk_par  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (state == ST_CLEAR) begin
                par[clr_cnt] <= 1'b0;
            end else begin
                if (c_wr) par[chunk_wr_line] <= ^chunk_in;
                if (h_wr) par[h_line] <= ^h_new;
            end
            chunk_par  <= par[chunk_rd_line];
            parity_err <= parity_err | ((^chunk_out) != chunk_par);
        end
    end
`endif

    lmem_beat_shifter #(
        .LINE_BITS (LINE_BITS),
        .BEAT_BITS (BEAT_BITS)
    ) u_shifter (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .line_in (mem[strm_line]),
        .ready   (strm_ready),
        .data    (strm_data),
        .valid   (strm_valid),
        .last    (strm_last),
        .done    (done)
    );

endmodule

// File: tb/tb_local_mem_bank.sv
// tb_local_mem_bank: random and directed traffic against a
// line-array reference model of the memory bank.
module tb_local_mem_bank;

    localparam int LB = 512;
    localparam int DP = 8;
    localparam int BB = 64;
    localparam int LW = 3;
    localparam int BW = 6;
    localparam int NB = LB / BB;

    logic          clk = 1'b0;
    logic          rst;
    logic          chunk_wr;
    logic [LW-1:0] chunk_wr_line;
    logic [LB-1:0] chunk_in;
    logic [LW-1:0] chunk_rd_line;
    logic [LB-1:0] chunk_out;
    logic          host_valid;
    logic          host_we;
    logic [LW+BW-1:0] host_addr;
    logic [7:0]    host_wdata;
    logic          host_ready;
    logic [7:0]    host_rdata;
    logic          host_rvalid;
    logic          clear;
    logic          strm_start;
    logic [LW-1:0] strm_line;
    logic          strm_ready;
    logic [BB-1:0] strm_data;
    logic          strm_valid;
    logic          strm_last;
    logic          busy;
`ifdef LMEM_PARITY_EN
    logic          parity_err;
`endif

    local_mem_bank #(
        .LINE_BITS (LB),
        .DEPTH     (DP),
        .BEAT_BITS (BB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .chunk_wr      (chunk_wr),
        .chunk_wr_line (chunk_wr_line),
        .chunk_in      (chunk_in),
        .chunk_rd_line (chunk_rd_line),
        .chunk_out     (chunk_out),
        .host_valid    (host_valid),
        .host_we       (host_we),
        .host_addr     (host_addr),
        .host_wdata    (host_wdata),
        .host_ready    (host_ready),
        .host_rdata    (host_rdata),
        .host_rvalid   (host_rvalid),
        .clear         (clear),
        .strm_start    (strm_start),
        .strm_line     (strm_line),
        .strm_ready    (strm_ready),
        .strm_data     (strm_data),
        .strm_valid    (strm_valid),
        .strm_last     (strm_last),
        .busy          (busy)
`ifdef LMEM_PARITY_EN
        ,
        .parity_err    (parity_err)
`endif
    );

    always #5 clk = ~clk;

    logic [LB-1:0] m_mem [DP];
    logic [LB-1:0] exp_cout;
    logic [7:0]    exp_rd;
    logic          exp_rv;
    bit            in_clear;
    int            clr_k;
    int            errors = 0;
    int            checks = 0;

    task automatic check(input string tag, input logic [LB-1:0] got,
                         input logic [LB-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [LB-1:0] rnd_line();
        logic [LB-1:0] r;
        for (int i = 0; i < LB / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Model one clock edge from the inputs currently driven.
    task automatic tick();
        logic [LW-1:0] hl;
        logic [BW-1:0] hb;
        logic          hr;
        #1;
        hl = host_addr[LW+BW-1:BW];
        hb = host_addr[BW-1:0];
        hr = !in_clear && !(host_we && chunk_wr && chunk_wr_line == hl);
        if (!rst) check("host_ready", host_ready, hr);
        if (rst) begin
            for (int i = 0; i < DP; i++) m_mem[i] = '0;
            exp_cout = '0;
            exp_rd   = '0;
            exp_rv   = 1'b0;
        end else begin
            exp_cout = m_mem[chunk_rd_line];
            exp_rv   = host_valid && hr && !host_we;
            if (exp_rv) exp_rd = m_mem[hl][hb*8 +: 8];
            if (in_clear) begin
                m_mem[clr_k] = '0;
                clr_k++;
            end else begin
                if (chunk_wr) m_mem[chunk_wr_line] = chunk_in;
                if (host_valid && hr && host_we)
                    m_mem[hl][hb*8 +: 8] = host_wdata;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs();
        check("chunk_out", chunk_out, exp_cout);
        check("host_rvalid", host_rvalid, exp_rv);
        check("host_rdata", host_rdata, exp_rd);
    endtask

    task automatic sweep_lines();
        for (int i = 0; i < DP + 1; i++) begin
            chunk_rd_line = LW'(i % DP);
            tick();
            check_outs();
        end
    endtask

    task automatic fill_lines();
        chunk_wr = 1'b1;
        for (int i = 0; i < DP; i++) begin
            chunk_wr_line = LW'(i);
            chunk_in = rnd_line();
            tick();
        end
        chunk_wr = 1'b0;
    endtask

    task automatic run_stream(input logic [LW-1:0] ln, input int rst_beat);
        logic [LB-1:0] snap;
        int k;
        int n;
        logic hs;
        chunk_wr = 1'b0;
        host_valid = 1'b0;
        snap = m_mem[ln];
        strm_start = 1'b1;
        strm_line = ln;
        tick();
        strm_start = 1'b0;
        check("strm_busy", busy, 1);
        k = 0;
        n = 0;
        while (k < NB && n < 64) begin
            strm_ready = ~n[0];
            chunk_wr = (n == 3);
            chunk_wr_line = ln;
            if (n == 3) chunk_in = rnd_line();
            strm_start = (n == 5);
            strm_line = ln + 1'b1;
            check("strm_valid", strm_valid, 1);
            check("strm_data", strm_data, snap[k*BB +: BB]);
            check("strm_last", strm_last, k == NB - 1);
            if (k == rst_beat) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                chunk_wr = 1'b0;
                strm_start = 1'b0;
                check("rst_svalid", strm_valid, 0);
                check("rst_busy", busy, 0);
                check("rst_sdata", strm_data, 0);
                check_outs();
                sweep_lines();
                return;
            end
            hs = strm_ready;
            tick();
            if (hs) k++;
            n++;
        end
        chunk_wr = 1'b0;
        strm_start = 1'b0;
        strm_ready = 1'b0;
        check("strm_beats", k, NB);
        check("strm_end_valid", strm_valid, 0);
        check("strm_end_last", strm_last, 0);
        check("strm_end_busy", busy, 0);
        chunk_rd_line = ln;
        tick();
        tick();
        check_outs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LB-1:0] pat;
        rst = 1'b1;
        chunk_wr = 1'b0;
        chunk_wr_line = '0;
        chunk_in = '0;
        chunk_rd_line = '0;
        host_valid = 1'b0;
        host_we = 1'b0;
        host_addr = '0;
        host_wdata = '0;
        clear = 1'b0;
        strm_start = 1'b0;
        strm_line = '0;
        strm_ready = 1'b0;
        in_clear = 1'b0;
        clr_k = 0;
        exp_rd = '0;
        @(posedge clk);
        tick();
        check_outs();
        check("rst_busy0", busy, 0);
        check("rst_svalid0", strm_valid, 0);
        check("rst_slast0", strm_last, 0);
        check("rst_sdata0", strm_data, 0);
        rst = 1'b0;
        tick();
        check_outs();

        chunk_wr = 1'b1;
        chunk_wr_line = 3'd3;
        for (int i = 0; i < LB / 8; i++) chunk_in[i*8 +: 8] = 8'(i * 17);
        pat = chunk_in;
        chunk_rd_line = 3'd3;
        tick();
        chunk_wr = 1'b0;
        check_outs();
        tick();
        check_outs();
        check("chunk_pattern", chunk_out, pat);

        host_valid = 1'b1;
        host_we = 1'b1;
        host_addr = {3'd2, 6'd5};
        host_wdata = 8'hA5;
        tick();
        check_outs();
        host_we = 1'b0;
        tick();
        check_outs();
        check("host_rd_a5", host_rdata, 8'hA5);
        check("host_rv_a5", host_rvalid, 1);
        host_valid = 1'b0;
        tick();
        check_outs();

        pat = rnd_line();
        chunk_wr = 1'b1;
        chunk_wr_line = 3'd4;
        chunk_in = pat;
        host_valid = 1'b1;
        host_we = 1'b1;
        host_addr = {3'd4, 6'd9};
        host_wdata = 8'h3C;
        #1;
        check("conflict_ready", host_ready, 0);
        tick();
        chunk_wr = 1'b0;
        host_valid = 1'b0;
        chunk_rd_line = 3'd4;
        tick();
        tick();
        check_outs();
        check("conflict_line", chunk_out, pat);

        for (int it = 0; it < 300; it++) begin
            chunk_wr = ($urandom_range(0, 3) == 0);
            chunk_wr_line = LW'($urandom);
            chunk_in = rnd_line();
            chunk_rd_line = LW'($urandom);
            host_valid = 1'($urandom);
            host_we = 1'($urandom);
            host_addr = 9'($urandom);
            if ($urandom_range(0, 3) == 0) host_addr[8:6] = chunk_wr_line;
            host_wdata = 8'($urandom);
            tick();
            check_outs();
        end
        chunk_wr = 1'b0;
        host_valid = 1'b0;

        fill_lines();
        run_stream(3'd1, -1);

        fill_lines();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        clr_k = 0;
        host_valid = 1'b1;
        for (int i = 0; i < DP; i++) begin
            check("clr_busy", busy, 1);
            check("clr_svalid", strm_valid, 0);
            host_we = 1'($urandom);
            host_addr = 9'($urandom);
            host_wdata = 8'($urandom);
            chunk_wr = 1'b1;
            chunk_wr_line = LW'($urandom);
            chunk_in = rnd_line();
            chunk_rd_line = LW'(i);
            strm_start = 1'b1;
            strm_line = '0;
            in_clear = 1'b1;
            tick();
            check_outs();
        end
        in_clear = 1'b0;
        chunk_wr = 1'b0;
        host_valid = 1'b0;
        strm_start = 1'b0;
        check("clr_done_busy", busy, 0);
        check("clr_no_stream", strm_valid, 0);
        sweep_lines();

        fill_lines();
        run_stream(3'd6, 3);

`ifdef LMEM_PARITY_EN
        check("parity_err", parity_err, 0);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/local_mem_bank.md
LOCAL_MEM_BANK -- requirements
Module: local_mem_bank

Interface
REQ-001 Parameter LINE_BITS, 512, width of one memory line in bits; SHALL be a multiple of BEAT_BITS and of 8.
REQ-002 Parameter DEPTH, 8, number of lines; SHALL be a power of two, at least 2.
REQ-003 Parameter BEAT_BITS, 64, width of one stream beat.
REQ-004 Derived: LW = log2(DEPTH), BW = log2(LINE_BITS/8), NBEATS = LINE_BITS/BEAT_BITS.
REQ-005 clk  in  1  single clock; all state changes on the rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 chunk_wr  in  1  write chunk_in to line chunk_wr_line.
REQ-008 chunk_wr_line  in  LW  target line for the chunk write.
REQ-009 chunk_in  in  LINE_BITS  full-line write data.
REQ-010 chunk_rd_line  in  LW  line selected for chunk_out.
REQ-011 chunk_out  out  LINE_BITS  registered copy of line chunk_rd_line, 1-cycle latency.
REQ-012 host_valid, host_we  in  1 each  host byte request; write when host_we=1.
REQ-013 host_addr  in  LW+BW  {line, byte}; byte 0 = bits [7:0].
REQ-014 host_wdata  in  8; host_ready out 1; host_rdata out 8; host_rvalid out 1.
REQ-015 clear  in  1  pulse; zero the whole array.
REQ-016 strm_start  in  1; strm_line in LW; strm_ready in 1.
REQ-017 strm_data  out  BEAT_BITS; strm_valid out 1; strm_last out 1; busy out 1.

Function
REQ-018 FSM states IDLE, STREAM, CLEAR; busy=1 outside IDLE.
REQ-019 IDLE: clear -> CLEAR (priority); else strm_start -> STREAM; starts outside IDLE ignored.
REQ-020 STREAM entry: snapshot line strm_line into a shift register; beat counter = 0; strm_valid=1 from the next cycle.
REQ-021 Beat k = snapshot bits [k*BEAT_BITS +: BEAT_BITS]; advance only on strm_valid & strm_ready; hold data while stalled.
REQ-022 strm_last=1 on beat NBEATS-1; its handshake returns FSM to IDLE, strm_valid=0 the next cycle.
REQ-023 Writes to the streamed line during STREAM SHALL NOT alter remaining beats.
REQ-024 CLEAR: zero one line per cycle, line 0 up to DEPTH-1, DEPTH cycles, then IDLE.
REQ-025 During CLEAR: chunk_wr ignored, host_ready=0, no strm_valid.
REQ-026 host_ready=1 outside CLEAR, except 0 when host_we and chunk_wr target the same line in that cycle (chunk write wins).
REQ-027 Host write accepted on host_valid & host_ready & host_we: byte updated at the edge.
REQ-028 Host read accepted on host_valid & host_ready & !host_we: host_rdata valid next cycle with host_rvalid=1 for one cycle; same-cycle write to that byte returns old data.
REQ-029 chunk_wr outside CLEAR writes the full line at the edge; chunk_out of the same line shows new data one cycle later.

Reset
REQ-030 rst SHALL zero the array in one cycle, force IDLE, counters 0.
REQ-031 Reset values: chunk_out 0, host_rdata 0, host_rvalid 0, strm_data 0, strm_valid 0, strm_last 0, busy 0; host_ready 1 after reset.
REQ-032 rst mid-STREAM or mid-CLEAR SHALL abort at once; rst overrides all inputs.

Configuration
REQ-033 Macro LMEM_PARITY_EN defined: per-line even-parity bit written with every line update; output parity_err (1 bit) set sticky when chunk_out's registered line fails check, cleared by rst.
REQ-034 Macro undefined: no parity storage, no parity_err port.

Structure
REQ-035 Shared package lmem_pkg: FSM state enum, default parameter constants, clog2 helper.
REQ-036 One sub-module lmem_beat_shifter: snapshot register, beat counter, valid/last logic.

Verification
REQ-037 chunk_wr line 3 = pattern i*8'h11 per byte; chunk_rd_line=3 -> chunk_out equals pattern one cycle later.
REQ-038 Host write 8'hA5 to {line 2, byte 5}; host read same -> host_rdata=8'hA5, host_rvalid 1 cycle after accept.
REQ-039 strm_start line 1, strm_ready toggled 1/0 -> 8 beats in order, strm_last only on beat 7, stalled data held.
REQ-040 chunk_wr and host write to line 4 same cycle -> host_ready=0, line 4 equals chunk_in.
REQ-041 clear after filling all lines -> busy for 8 cycles, all reads 0, host_ready 0 throughout.
REQ-042 rst asserted on beat 3 of a stream -> strm_valid 0, busy 0 next cycle, array zero.
